// File: rtl/fil2dma_pkg.sv
// fil2dma packer shared types: word widths, FIFO depth,
// the packed FIFO entry {data, keep, last} and the packer state.
package fil2dma_pkg;

    localparam int FIL_W      = 16;
    localparam int DMA_W      = 2 * FIL_W;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef struct packed {
        logic [DMA_W-1:0] data;
        logic [1:0]       keep;
        logic             last;
    } entry_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pk_state_e;

endpackage

// File: rtl/fil2dma_if.sv
// fil2dma bus: filtered input stream, packed DMA output stream and
// FIFO occupancy. master = producer/consumer side, slave = packer.
interface fil2dma_if;
    import fil2dma_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [FIL_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [DMA_W-1:0] out_data;
    logic [1:0]       out_keep;
    logic             out_last;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep,
        input  out_last, fifo_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep,
        output out_last, fifo_count
    );

endinterface

// File: rtl/fil2dma_syncfifo.sv
// Single-clock entry FIFO, FIFO_DEPTH deep, power-of-two pointers.
// Ports: fil_clk, fil_rst, push/din, pop/dout (zero when empty), count.
module fil2dma_syncfifo
    import fil2dma_pkg::*;
(
    input  logic             fil_clk,
    input  logic             fil_rst,
    input  logic             push,
    input  entry_t           din,
    input  logic             pop,
    output entry_t           dout,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Guards make over/underflow impossible even on a bad caller.
    assign push_ok = push && (count != CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop && (count != '0);

    always_ff @(posedge fil_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at PTR_W bits.
    always_ff @(posedge fil_clk) begin
        if (fil_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stale memory never leaks out: fields are forced to zero when empty.
    assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fil2dma_packer.sv
// Packs pairs of FIL_W filtered words into DMA_W words (low = older)
// with keep/last, buffered through fil2dma_syncfifo. Ports: fil_clk, fil_rst, bus.
module fil2dma_packer
    import fil2dma_pkg::*;
(
    input  logic      fil_clk,
    input  logic      fil_rst,
    fil2dma_if.slave  bus
);

    pk_state_e        state;
    logic [FIL_W-1:0] held;
    logic             acc;
    logic             push;
    logic             pop;
    entry_t           push_e;
    entry_t           head;
    logic [CNT_W-1:0] count;

    assign bus.in_ready = !fil_rst && (count != CNT_W'(FIFO_DEPTH));
    assign acc          = bus.in_valid && bus.in_ready;

    // A word pushes when it completes a pair or closes a transfer.
    assign push = acc && ((state == HALF) || bus.in_last);

    always_comb begin
        push_e = '0;
        if (state == HALF) begin
            push_e.data = {bus.in_data, held};
            push_e.keep = 2'b11;
            push_e.last = bus.in_last;
        end else begin
            push_e.data = {{FIL_W{1'b0}}, bus.in_data};
            push_e.keep = 2'b01;
            push_e.last = 1'b1;
        end
    end

    // HALF waits indefinitely for its partner; no timeout flush.
    always_ff @(posedge fil_clk) begin
        if (fil_rst) begin
            state <= EMPTY;
            held  <= '0;
        end else if (acc) begin
            unique case (state)
                EMPTY: begin
                    if (!bus.in_last) begin
                        held  <= bus.in_data;
                        state <= HALF;
                    end
                end
                HALF: begin
                    held  <= '0;
                    state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign pop = bus.out_valid && bus.out_ready;

    fil2dma_syncfifo u_fifo (
        .fil_clk (fil_clk),
        .fil_rst (fil_rst),
        .push    (push),
        .din     (push_e),
        .pop     (pop),
        .dout    (head),
        .count   (count)
    );

    assign bus.fifo_count = count;
    assign bus.out_valid  = (count != '0);
    assign bus.out_data   = head.data;
    assign bus.out_keep   = head.keep;
    assign bus.out_last   = head.last;

endmodule

// File: tb/tb_fil2dma_packer.sv
// Directed bench for fil2dma_packer: reset, pairing, last flush,
// backpressure, streaming across wrap, HALF hold and mid-run reset.
module tb_fil2dma_packer;
    import fil2dma_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    fil2dma_if bus();

    fil2dma_packer dut (
        .fil_clk (clk),
        .fil_rst (rst),
        .bus     (bus)
    );

    function automatic logic [DMA_W+2:0] outv();
        return {bus.out_data, bus.out_keep, bus.out_last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic feed(input logic [FIL_W-1:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        repeat (3) step();
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_valid got %b want 0", bus.out_valid);
        end
        nvec++;
        if (bus.fifo_count !== 3'd0) begin
            nerr++;
            $display("FAIL rst_count got %0d want 0", bus.fifo_count);
        end
        nvec++;
        if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rst_ready got %b want 0", bus.in_ready);
        end
        nvec++;
        if (outv() !== '0) begin
            nerr++;
            $display("FAIL rst_fields got %h want 0", outv());
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_release_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_pack();
        bus.out_ready = 1'b1;
        feed(16'h1111, 1'b0);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL pack_half_valid got %b want 0", bus.out_valid);
        end
        feed(16'h2222, 1'b0);
        idle();
        nvec++;
        if (outv() !== {32'h22221111, 2'b11, 1'b0}) begin
            nerr++;
            $display("FAIL pack_entry got %h want %h",
                     outv(), {32'h22221111, 2'b11, 1'b0});
        end
        nvec++;
        if (bus.out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL pack_valid got %b want 1", bus.out_valid);
        end
        step();
        nvec++;
        if ({bus.out_valid, outv()} !== '0) begin
            nerr++;
            $display("FAIL pack_drain got %b/%h want 0/0",
                     bus.out_valid, outv());
        end
    endtask

    task automatic test_last();
        bus.out_ready = 1'b1;
        feed(16'hABCD, 1'b1);
        idle();
        nvec++;
        if (outv() !== {32'h0000ABCD, 2'b01, 1'b1}) begin
            nerr++;
            $display("FAIL last_entry got %h want %h",
                     outv(), {32'h0000ABCD, 2'b01, 1'b1});
        end
        step();
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL last_drain got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [DMA_W+2:0] exp;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            feed(16'(16'h1000 + i), 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        step();
        step();
        idle();
        nvec++;
        if (bus.fifo_count !== 3'd4) begin
            nerr++;
            $display("FAIL bp_count got %0d want 4", bus.fifo_count);
        end
        nvec++;
        if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL bp_ready got %b want 0", bus.in_ready);
        end
        exp = {32'h10011000, 2'b11, 1'b0};
        nvec++;
        if (outv() !== exp) begin
            nerr++;
            $display("FAIL bp_stable got %h want %h", outv(), exp);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = {16'(16'h1000 + 2 * k + 1), 16'(16'h1000 + 2 * k),
                   2'b11, 1'b0};
            nvec++;
            if (outv() !== exp) begin
                nerr++;
                $display("FAIL bp_order%0d got %h want %h", k, outv(), exp);
            end
            step();
            if (k == 0) begin
                nvec++;
                if (bus.in_ready !== 1'b1) begin
                    nerr++;
                    $display("FAIL bp_reready got %b want 1", bus.in_ready);
                end
            end
        end
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL bp_empty got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int               got;
        logic [DMA_W+2:0] exp;
        got = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                nvec++;
                if (bus.in_ready !== 1'b1) begin
                    nerr++;
                    $display("FAIL b2b_ready%0d got %b want 1",
                             i, bus.in_ready);
                end
                feed(16'(16'h2000 + i), 1'b0);
            end else begin
                idle();
                step();
            end
            if (bus.out_valid === 1'b1) begin
                exp = {16'(16'h2000 + 2 * got + 1), 16'(16'h2000 + 2 * got),
                       2'b11, 1'b0};
                nvec++;
                if (outv() !== exp) begin
                    nerr++;
                    $display("FAIL b2b_entry%0d got %h want %h",
                             got, outv(), exp);
                end
                got++;
            end
        end
        nvec++;
        if (got !== 10) begin
            nerr++;
            $display("FAIL b2b_total got %0d want 10", got);
        end
    endtask

    task automatic test_half_hold();
        bus.out_ready = 1'b1;
        feed(16'h7777, 1'b0);
        idle();
        repeat (10) step();
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL hold_valid got %b want 0", bus.out_valid);
        end
        feed(16'h8888, 1'b1);
        idle();
        nvec++;
        if (outv() !== {32'h88887777, 2'b11, 1'b1}) begin
            nerr++;
            $display("FAIL hold_entry got %h want %h",
                     outv(), {32'h88887777, 2'b11, 1'b1});
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            feed(16'(16'h3000 + i), 1'b0);
        end
        idle();
        nvec++;
        if (bus.fifo_count !== 3'd2) begin
            nerr++;
            $display("FAIL mid_count got %0d want 2", bus.fifo_count);
        end
        rst = 1'b1;
        step();
        nvec++;
        if ({bus.out_valid, bus.fifo_count} !== '0) begin
            nerr++;
            $display("FAIL mid_rst got %b/%0d want 0/0",
                     bus.out_valid, bus.fifo_count);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        feed(16'h4444, 1'b0);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL mid_half got %b want 0", bus.out_valid);
        end
        feed(16'h5555, 1'b0);
        idle();
        nvec++;
        if (outv() !== {32'h55554444, 2'b11, 1'b0}) begin
            nerr++;
            $display("FAIL mid_entry got %h want %h",
                     outv(), {32'h55554444, 2'b11, 1'b0});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_pack();
        test_last();
        test_backpressure();
        test_back_to_back();
        test_half_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
